// File: rtl/pc_pkg.sv
// Shared constants, state/select enums and arithmetic helpers for the
// program-counter sequencer.
package pc_pkg;

    localparam int D  = 12;  // PC / jump-target width
    localparam int IW = 8;   // jump-target LUT index width
    localparam int OW = 8;   // relative branch offset width
    localparam int CW = 16;  // cycle counter width

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_e;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_BR,
        PC_JMP,
        PC_RET,
        PC_START
    } pc_sel_e;

    // PC plus a sign-extended branch offset, wrapping modulo 2^D.
    function automatic logic [D-1:0] pc_add_off(input logic [D-1:0]  pc,
                                                input logic [OW-1:0] off);
        return pc + {{(D-OW){off[OW-1]}}, off};
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority decode of the per-cycle control inputs into a next-PC select,
// plus the combinational index mux that feeds the external jump-target LUT.
module pc_next_sel
    import pc_pkg::*;
(
    input  state_e          state,
    input  logic            start,
    input  logic [IW-1:0]   prog_sel,
    input  logic            stall,
    input  logic            halt,
    input  logic            jump,
    input  logic [IW-1:0]   jump_idx,
    input  logic            ret,
    input  logic            br_taken,
    output pc_sel_e         pc_sel,
    output logic            halt_en,
    output logic            count_en,
    output logic [IW-1:0]   lut_addr
);

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_sel   = PC_HOLD;
        halt_en  = 1'b0;
        count_en = 1'b0;
        lut_addr = prog_sel;

        case (state)
            RUN: begin
                lut_addr = jump_idx;
                if (!stall) begin
                    count_en = 1'b1;
                    if (halt)          halt_en = 1'b1;
                    else if (ret)      pc_sel  = PC_RET;
                    else if (jump)     pc_sel  = PC_JMP;
                    else if (br_taken) pc_sel  = PC_BR;
                    else               pc_sel  = PC_INC;
                end
            end
            default: begin
                // IDLE and HALTED only react to Start; Stall has no effect here.
                if (start) pc_sel = PC_START;
            end
        endcase
    end

endmodule

// File: rtl/prog_ctr_seq.sv
// Program-counter sequencer: holds the PC, link register, run state and a
// saturating cycle counter; drives the index side of the external jump LUT.
module prog_ctr_seq
    import pc_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [IW-1:0]   ProgSel,
    input  logic            Stall,
    input  logic            Halt,
    input  logic            Jump,
    input  logic [IW-1:0]   JumpIdx,
    input  logic            Link,
    input  logic            Ret,
    input  logic            BrTaken,
    input  logic [OW-1:0]   BrOff,
    output logic [IW-1:0]   LutAddr,
    input  logic [D-1:0]    LutTarget,
    output logic [D-1:0]    ProgCtr,
    output logic            Running,
    output logic            Done,
    output logic [CW-1:0]   CycleCnt
);

    state_e         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic [D-1:0]   link_q, link_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           running_q, running_d;
    logic           done_q, done_d;

    pc_sel_e        pc_sel;
    logic           halt_en;
    logic           count_en;

    pc_next_sel u_next_sel (
        .state    (state_q),
        .start    (Start),
        .prog_sel (ProgSel),
        .stall    (Stall),
        .halt     (Halt),
        .jump     (Jump),
        .jump_idx (JumpIdx),
        .ret      (Ret),
        .br_taken (BrTaken),
        .pc_sel   (pc_sel),
        .halt_en  (halt_en),
        .count_en (count_en),
        .lut_addr (LutAddr)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        link_d  = link_q;
        cnt_d   = cnt_q;

        case (pc_sel)
            PC_START: begin
                pc_d    = LutTarget;
                link_d  = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            PC_INC: pc_d = pc_q + 1'b1;
            PC_BR:  pc_d = pc_add_off(pc_q, BrOff);
            PC_JMP: begin
                pc_d = LutTarget;
                // Link only matters on a jump: it turns the jump into a call.
                if (Link) link_d = pc_q + 1'b1;
            end
            PC_RET: pc_d = link_q;
            default: ;
        endcase

        if (halt_en)  state_d = HALTED;
        if (count_en) cnt_d   = sat_inc(cnt_q);

        running_d = (state_d == RUN);
        done_d    = (state_d == HALTED);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            link_q    <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            link_q    <= link_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign ProgCtr  = pc_q;
    assign Running  = running_q;
    assign Done     = done_q;
    assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Directed, scoreboard-checked bench for prog_ctr_seq with a small
// behavioural jump-target LUT beside the DUT.
module tb_prog_ctr_seq;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [7:0]  ProgSel;
    logic        Stall;
    logic        Halt;
    logic        Jump;
    logic [7:0]  JumpIdx;
    logic        Link;
    logic        Ret;
    logic        BrTaken;
    logic [7:0]  BrOff;
    logic [7:0]  LutAddr;
    logic [11:0] LutTarget;
    logic [11:0] ProgCtr;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [11:0] pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 Clk = ~Clk;

    function automatic logic [11:0] lut(input logic [7:0] a);
        case (a)
            8'd0:    return 12'd0;
            8'd1:    return 12'd17;
            8'd2:    return 12'd30;
            8'd3:    return 12'd54;
            8'd4:    return 12'd40;
            8'd5:    return 12'd60;
            8'd6:    return 12'd3;
            8'd7:    return 12'd4095;
            default: return {4'h0, a} + 12'd100;
        endcase
    endfunction

    assign LutTarget = lut(LutAddr);

    prog_ctr_seq dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .ProgSel   (ProgSel),
        .Stall     (Stall),
        .Halt      (Halt),
        .Jump      (Jump),
        .JumpIdx   (JumpIdx),
        .Link      (Link),
        .Ret       (Ret),
        .BrTaken   (BrTaken),
        .BrOff     (BrOff),
        .LutAddr   (LutAddr),
        .LutTarget (LutTarget),
        .ProgCtr   (ProgCtr),
        .Running   (Running),
        .Done      (Done),
        .CycleCnt  (CycleCnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ctl(input logic st, input logic [7:0] ps, input logic sl,
                       input logic hl, input logic jp, input logic [7:0] ji,
                       input logic lk, input logic rt, input logic br,
                       input logic [7:0] off);
        Start   = st;  ProgSel = ps;  Stall = sl;  Halt    = hl;
        Jump    = jp;  JumpIdx = ji;  Link  = lk;  Ret     = rt;
        BrTaken = br;  BrOff   = off;
    endtask

    task automatic idle();
        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic expect_out(input string tag, input logic [11:0] pc, input logic run,
                              input logic done, input logic [15:0] cnt);
        exp_t e;
        e.tag = tag; e.pc = pc; e.run = run; e.done = done; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            check({e.tag, ".pc"},   {20'd0, ProgCtr},  {20'd0, e.pc});
            check({e.tag, ".run"},  {31'd0, Running},  {31'd0, e.run});
            check({e.tag, ".done"}, {31'd0, Done},     {31'd0, e.done});
            check({e.tag, ".cnt"},  {16'd0, CycleCnt}, {16'd0, e.cnt});
        end
    endtask

    // Inputs are already set; push the expectation, take one edge, compare.
    task automatic step(input string tag, input logic [11:0] pc, input logic run,
                        input logic done, input logic [15:0] cnt);
        expect_out(tag, pc, run, done, cnt);
        @(posedge Clk);
        #1;
        pop_check();
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        #12;
        expect_out("reset", 12'd0, 1'b0, 1'b0, 16'd0);
        pop_check();
        @(negedge Clk);
        Reset = 1'b0;

        // LUT index follows ProgSel while idle
        ctl(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 8'd0);
        #1;
        check("lutaddr_idle", {24'd0, LutAddr}, 32'd2);
        step("start_p2", 12'd30, 1'b1, 1'b0, 16'd0);

        idle(); step("free1", 12'd31, 1'b1, 1'b0, 16'd1);
        idle(); step("free2", 12'd32, 1'b1, 1'b0, 16'd2);
        idle(); step("free3", 12'd33, 1'b1, 1'b0, 16'd3);

        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 8'd0);
        step("jump_40", 12'd40, 1'b1, 1'b0, 16'd4);

        // call: link register should capture 41
        ctl(1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        #1;
        check("lutaddr_run", {24'd0, LutAddr}, 32'd3);
        step("call_54", 12'd54, 1'b1, 1'b0, 16'd5);
        idle(); step("after_call1", 12'd55, 1'b1, 1'b0, 16'd6);
        idle(); step("after_call2", 12'd56, 1'b1, 1'b0, 16'd7);
        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        step("ret_41", 12'd41, 1'b1, 1'b0, 16'd8);

        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd0);
        step("jump_60", 12'd60, 1'b1, 1'b0, 16'd9);
        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'hF6);
        step("br_m10", 12'd50, 1'b1, 1'b0, 16'd10);
        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 8'd0);
        step("jump_3", 12'd3, 1'b1, 1'b0, 16'd11);
        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'hFB);
        step("br_wrap", 12'd4094, 1'b1, 1'b0, 16'd12);
        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 8'd0);
        step("jump_4095", 12'd4095, 1'b1, 1'b0, 16'd13);
        idle(); step("inc_wrap", 12'd0, 1'b1, 1'b0, 16'd14);

        // stall masks halt and jump, counter frozen
        ctl(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0);
        step("stall1", 12'd0, 1'b1, 1'b0, 16'd14);
        step("stall2", 12'd0, 1'b1, 1'b0, 16'd14);

        ctl(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step("halt", 12'd0, 1'b0, 1'b1, 16'd15);
        ctl(1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 8'd0);
        #1;
        check("lutaddr_halted", {24'd0, LutAddr}, 32'd1);
        step("halted_hold", 12'd0, 1'b0, 1'b1, 16'd15);

        // restart from HALTED with Stall high: Stall ignored outside RUN
        ctl(1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step("restart_17", 12'd17, 1'b1, 1'b0, 16'd0);
        idle(); step("inc_18", 12'd18, 1'b1, 1'b0, 16'd1);
        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        step("call_30", 12'd30, 1'b1, 1'b0, 16'd2);
        idle(); step("inc_31", 12'd31, 1'b1, 1'b0, 16'd3);

        ctl(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 8'd5);
        step("prio_halt", 12'd31, 1'b0, 1'b1, 16'd4);

        // restart clears link: return goes to 0, not 19
        ctl(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step("restart_54", 12'd54, 1'b1, 1'b0, 16'd0);
        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        step("ret_cleared", 12'd0, 1'b1, 1'b0, 16'd1);
        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        step("call_from_0", 12'd54, 1'b1, 1'b0, 16'd2);
        idle(); step("inc_55", 12'd55, 1'b1, 1'b0, 16'd3);
        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        step("link_alone", 12'd56, 1'b1, 1'b0, 16'd4);
        ctl(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 8'd0);
        step("prio_ret", 12'd1, 1'b1, 1'b0, 16'd5);
        ctl(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step("start_in_run", 12'd2, 1'b1, 1'b0, 16'd6);

        // asynchronous reset between edges
        idle();
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        expect_out("async_reset", 12'd0, 1'b0, 1'b0, 16'd0);
        pop_check();
        @(negedge Clk);
        Reset = 1'b0;
        step("post_reset1", 12'd0, 1'b0, 1'b0, 16'd0);
        step("post_reset2", 12'd0, 1'b0, 1'b0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_ctr_seq.md
Name: prog_ctr_seq

Overview:
- Program-counter sequencer that drives the index side of the jump-target lookup table (PC_LUT) and consumes its returned absolute target.
- Holds the 12-bit PC and launches a program from a start/program-select handshake.
- Each cycle it advances, jumps absolutely through the LUT, branches relatively, calls/returns via a one-deep link register, stalls, or halts.
- Signals Done on halt, and counts executed cycles for the test harness.

Parameters:
- D, 12, PC / target width (matches PC_LUT target width).
- IW, 8, LUT index width (matches PC_LUT addr width).
- OW, 8, relative branch offset width (two's complement).
- CW, 16, cycle counter width.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  launch/restart program; sampled in IDLE or HALTED.
- ProgSel  input  IW  LUT index of program entry point, used with Start.
- Stall  input  1  freeze PC, state, link register and counter.
- Halt  input  1  decoded halt instruction.
- Jump  input  1  absolute jump through LUT.
- JumpIdx  input  IW  LUT index for Jump.
- Link  input  1  with Jump: save PC+1 into link register (call).
- Ret  input  1  return: PC <= link register.
- BrTaken  input  1  relative branch taken.
- BrOff  input  OW  signed branch offset.
- LutAddr  output  IW  combinational index into PC_LUT.
- LutTarget  input  D  combinational target returned by PC_LUT.
- ProgCtr  output  D  current PC (registered).
- Running  output  1  high in RUN state.
- Done  output  1  high in HALTED state.
- CycleCnt  output  CW  RUN cycles since last start, saturating.

Behaviour:
- Reset (async, any time, including mid-program): state IDLE, ProgCtr=0, link=0, CycleCnt=0, Running=0, Done=0. Takes effect immediately, without waiting for a clock edge.
- States: IDLE, RUN, HALTED.
- LutAddr mux (combinational): ProgSel in IDLE/HALTED; JumpIdx in RUN. PC_LUT is combinational, so LutTarget is valid in the same cycle.
- IDLE/HALTED with Start=1:
  - next edge: ProgCtr <= LutTarget, CycleCnt <= 0, link <= 0, state RUN.
  - Done drops and Running rises on that same edge.
  - Stall is ignored outside RUN.
- IDLE/HALTED with Start=0: hold all state. Done stays 1 in HALTED.
- RUN, per edge, priority highest first:
  1. Stall: hold everything, including CycleCnt. Halt/Jump/Ret/BrTaken are ignored this cycle.
  2. Halt: state HALTED; ProgCtr holds (points at halt instruction); CycleCnt increments once.
  3. Ret: ProgCtr <= link.
  4. Jump: ProgCtr <= LutTarget. If Link=1, link <= ProgCtr+1 (mod 2^D).
  5. BrTaken: ProgCtr <= ProgCtr + sign_extend(BrOff), modulo 2^D.
  6. Otherwise: ProgCtr <= ProgCtr+1.
- Start in RUN is ignored.
- Link without Jump is ignored.
- Jump to index 0 is legal (target 0).
- Arithmetic: all PC arithmetic is D-bit unsigned with wrap. 4095+1 -> 0; 3 + (-5) -> 4094.
- CycleCnt increments on every non-stalled RUN edge, including the halting edge. Saturates at 2^CW-1.
- Latency: a control input sampled at edge N produces the new ProgCtr visible after edge N. There are no delay slots.

Decomposition:
- Shared package (pc_pkg):
  - D, IW, OW, CW constants.
  - state enum {IDLE, RUN, HALTED}.
  - next-PC select enum {PC_HOLD, PC_INC, PC_BR, PC_JMP, PC_RET, PC_START}.
- One natural sub-module: pc_next_sel. It is combinational priority decode producing the select enum and the LutAddr mux.
- The register/state logic stays in prog_ctr_seq.
- PC_LUT is instantiated beside this block at the top level, not inside it.

Test Plan:
- Reset then Start=1, ProgSel=2 (LUT 2 -> 30): ProgCtr=30, Running=1 after one edge; three free cycles -> 31, 32, 33; CycleCnt=3.
- At PC=40, Jump=1, JumpIdx=3, Link=1: ProgCtr=54, link=41. Two cycles later Ret=1 -> ProgCtr=41.
- At PC=60, BrTaken=1, BrOff=8'hF6 (-10) -> 50. At PC=3, BrOff=-5 -> 4094. At PC=4095, no control -> 0.
- Stall=1 together with Halt=1 and Jump=1 for 2 cycles: ProgCtr and CycleCnt unchanged, state RUN. Then Halt alone -> Done=1, Running=0, ProgCtr unchanged. Start=1, ProgSel=1 -> ProgCtr=17, Done=0.
- Priority: Halt, Ret, Jump and BrTaken asserted together -> HALTED, PC held. Then Ret+Jump together in RUN -> PC=link.
- Assert Reset asynchronously between clock edges mid-RUN: outputs go to ProgCtr=0, Running=0, Done=0, CycleCnt=0 before the next edge. After release, with Start=0, the block remains IDLE.
